// File: rtl/event_mon_pkg.sv
// Shared types and widths for the event monitor datapath.
// Contents:
//   arb_state_t - ingress arbiter FSM states
//   EVT_W       - event word width, shared with sync_fifo
//   FIFO_DEPTH  - event FIFO depth, shared with sync_fifo
//   id_width()  - width of a source index (at least 1 bit)
package event_mon_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned EVT_W      = 72;
  localparam int unsigned FIFO_DEPTH = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req        - per-source request vector
//   last_owner - most recently served source; it gets lowest priority
//   gnt_id     - first requester found scanning last_owner+1, +2, ... modulo N_SRC
//   gnt_any    - at least one request is present
module rr_pick
  import event_mon_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  localparam int unsigned IdW  = id_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IdW-1:0]   last_owner,
  output logic [IdW-1:0]   gnt_id,
  output logic             gnt_any
);

  always_comb begin
    gnt_id  = last_owner;
    gnt_any = 1'b0;
    // Scan from the farthest offset inwards so the nearest requester is written last and wins.
    for (int k = int'(N_SRC); k >= 1; k--) begin
      int idx;
      idx = (int'(last_owner) + k) % int'(N_SRC);
      if (req[idx]) begin
        gnt_id  = IdW'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_ingress_arb.sv
// Round-robin ingress arbiter in front of the event sync FIFO.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   enable          - allows new grants
//   src_valid/data  - per-source event streams (source i at src_data[i*W +: W])
//   src_ready       - combinational per-source accept
//   fifo_push/_data - registered push toward the FIFO
//   fifo_count      - FIFO occupancy
//   grant_valid/id  - current grant owner
//   accept_cnt      - per-source saturating accepted-beat counters
module event_ingress_arb
  import event_mon_pkg::*;
#(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned W      = EVT_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned BURST  = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned IdW   = id_width(N_SRC),
  localparam int unsigned FcW   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*W-1:0]     src_data,
  output logic [N_SRC-1:0]       src_ready,
  output logic                   fifo_push,
  output logic [W-1:0]           fifo_push_data,
  input  logic [FcW-1:0]         fifo_count,
  output logic                   grant_valid,
  output logic [IdW-1:0]         grant_id,
  output logic [N_SRC*CNT_W-1:0] accept_cnt
);

  localparam int unsigned BcW = $clog2(BURST + 1);

  arb_state_t             state_q, state_d;
  logic [IdW-1:0]         grant_id_q, grant_id_d;
  logic [IdW-1:0]         last_owner_q, last_owner_d;
  logic [BcW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                   fifo_push_q, fifo_push_d;
  logic [W-1:0]           push_data_q, push_data_d;
  logic [N_SRC*CNT_W-1:0] cnt_q, cnt_d;

  logic [IdW-1:0] pick_id;
  logic           pick_any;
  logic           space;
  logic           owner_valid;
  logic           accept;
  logic           last_beat;

  rr_pick #(
    .N_SRC (N_SRC)
  ) u_rr_pick (
    .req        (src_valid),
    .last_owner (last_owner_q),
    .gnt_id     (pick_id),
    .gnt_any    (pick_any)
  );

  // The push still in flight already owns a slot; pops are ignored, so this never overestimates.
  assign space = ({1'b0, fifo_count} + (FcW + 1)'(fifo_push_q)) < (FcW + 1)'(DEPTH);

  assign owner_valid = src_valid[grant_id_q];
  assign accept      = (state_q == GRANT) && owner_valid && space && enable;
  assign last_beat   = (32'(beat_cnt_q) + 32'd1) == BURST;

  always_comb begin
    src_ready             = '0;
    src_ready[grant_id_q] = accept;
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    fifo_push_d  = accept;
    push_data_d  = push_data_q;
    cnt_d        = cnt_q;

    if (accept) begin
      push_data_d = src_data[grant_id_q*W +: W];
    end

    unique case (state_q)
      IDLE: begin
        if (enable && pick_any && space) begin
          state_d    = GRANT;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BcW'(1);
        end
        if (!owner_valid || !enable || !space || (accept && last_beat)) begin
          state_d      = IDLE;
          last_owner_d = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < int'(N_SRC); i++) begin
      if (accept && (grant_id_q == IdW'(i)) && (cnt_q[i*CNT_W +: CNT_W] != '1)) begin
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_owner_q <= IdW'(N_SRC - 1);
      beat_cnt_q   <= '0;
      fifo_push_q  <= 1'b0;
      push_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      fifo_push_q  <= fifo_push_d;
      push_data_q  <= push_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign fifo_push      = fifo_push_q;
  assign fifo_push_data = push_data_q;
  assign grant_valid    = (state_q == GRANT);
  assign grant_id       = grant_id_q;
  assign accept_cnt     = cnt_q;

endmodule

// File: tb/tb_event_ingress_arb.sv
// Self-checking bench for event_ingress_arb: a per-cycle behavioural model plus directed
// literal expectations, with a simple FIFO occupancy model feeding fifo_count.
module tb_event_ingress_arb;
  import event_mon_pkg::*;

  localparam int N     = 4;
  localparam int W     = EVT_W;
  localparam int DEPTH = FIFO_DEPTH;
  localparam int BURST = 4;
  localparam int CNT_W = 4;
  localparam int FCW   = $clog2(DEPTH + 1);
  localparam int IDW   = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [N-1:0]     src_valid;
  logic [N*W-1:0]   src_data;
  logic [N-1:0]     src_ready;
  logic             fifo_push;
  logic [W-1:0]     fifo_push_data;
  logic [FCW-1:0]   fifo_count;
  logic             grant_valid;
  logic [IDW-1:0]   grant_id;
  logic [N*CNT_W-1:0] accept_cnt;

  event_ingress_arb #(
    .N_SRC (N),
    .W     (W),
    .DEPTH (DEPTH),
    .BURST (BURST),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .fifo_push      (fifo_push),
    .fifo_push_data (fifo_push_data),
    .fifo_count     (fifo_count),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .accept_cnt     (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Reference model state: owner < 0 means no grant is held.
  bit         m_ok;
  int         m_owner;
  int         m_last;
  int         m_gid;
  int         m_beats;
  bit         m_push;
  logic [W-1:0] m_data;
  int         m_cnt [N];

  // Stimulus / environment state.
  int     rem [N];
  int     seq [N];
  int     acc_tot [N];
  logic [N-1:0] acc_flag;
  bit     rnd_v;
  bit     drain;
  int     pops_req;
  int     pops_done;
  int     fcount_next;

  // Observation statistics for the directed phases.
  int     push_total;
  int     run_src;
  int     run_len;
  int     max_run;
  bit     gv_prev;
  int     grant_log [$];
  bit     rec_on;
  bit     rec_started;
  int     rec_n;
  logic [11:0] hist;
  bit     ord_on;
  int     ord_seq;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic observe();
    logic [N-1:0]       e_rdy;
    logic [N*CNT_W-1:0] e_cnt;
    bit sp;
    bit pop;
    bit acc;
    bit found;
    int o;

    pop = (drain || (pops_done < pops_req)) && (fifo_count != '0);
    if (pop && !drain) pops_done++;
    if (fifo_push === 1'b1) begin
      chk("no_overflow", 128'(int'(fifo_count) + 1 - int'(pop) > DEPTH), 128'(0));
    end
    fcount_next = int'(fifo_count) + int'(fifo_push) - int'(pop);

    acc_flag = src_valid & src_ready;
    for (int i = 0; i < N; i++) if (acc_flag[i] === 1'b1) acc_tot[i]++;

    if (fifo_push === 1'b1) begin
      push_total++;
      if (int'(fifo_push_data[71:64]) == run_src) run_len++;
      else begin
        run_src = int'(fifo_push_data[71:64]);
        run_len = 1;
      end
      if (run_len > max_run) max_run = run_len;
      if (ord_on) begin
        chk("p2_order", 128'(fifo_push_data[63:32]), 128'(ord_seq));
        ord_seq++;
      end
    end
    if (rec_on && (rec_started || fifo_push === 1'b1)) begin
      rec_started = 1'b1;
      if (rec_n < 12) begin
        hist = {hist[10:0], fifo_push};
        rec_n++;
      end
    end
    if (grant_valid === 1'b1 && !gv_prev) grant_log.push_back(int'(grant_id));
    gv_prev = (grant_valid === 1'b1);

    sp    = (int'(fifo_count) + int'(m_push)) < DEPTH;
    e_rdy = '0;
    if (m_owner >= 0 && src_valid[m_owner] && sp && enable) e_rdy[m_owner] = 1'b1;
    for (int i = 0; i < N; i++) e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);

    if (m_ok) begin
      chk("src_ready", 128'(src_ready), 128'(e_rdy));
      chk("fifo_push", 128'(fifo_push), 128'(m_push));
      chk("push_data", 128'(fifo_push_data), 128'(m_data));
      chk("grant_valid", 128'(grant_valid), 128'(m_owner >= 0));
      chk("grant_id", 128'(grant_id), 128'(m_gid));
      chk("accept_cnt", 128'(accept_cnt), 128'(e_cnt));
    end

    if (!rst_n) begin
      m_ok    = 1'b1;
      m_owner = -1;
      m_last  = N - 1;
      m_gid   = 0;
      m_beats = 0;
      m_push  = 1'b0;
      m_data  = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (m_ok) begin
      acc    = (m_owner >= 0) && e_rdy[m_owner];
      m_push = acc;
      if (acc) begin
        m_data = src_data[m_owner*W +: W];
        if (m_cnt[m_owner] < CMAX) m_cnt[m_owner]++;
        m_beats++;
      end
      if (m_owner < 0) begin
        found = 1'b0;
        if (enable && sp) begin
          for (int k = 1; k <= N; k++) begin
            o = (m_last + k) % N;
            if (!found && src_valid[o]) begin
              found   = 1'b1;
              m_owner = o;
              m_gid   = o;
              m_beats = 0;
            end
          end
        end
      end else if (!src_valid[m_owner] || !enable || !sp || (acc && m_beats == BURST)) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  // Sources hold valid and data until accepted; new words carry {source, sequence, random}.
  task automatic drive();
    fifo_count = FCW'(fcount_next);
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i] === 1'b1) begin
        seq[i]++;
        if (rem[i] > 0) rem[i]--;
      end
      if (!(src_valid[i] && acc_flag[i] !== 1'b1)) begin
        src_valid[i]        = (rem[i] != 0) && (!rnd_v || $urandom_range(3) != 0);
        src_data[i*W +: W]  = {8'(i), 32'(seq[i]), 32'($urandom())};
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b1;
    drain     = 1'b1;
    rnd_v     = 1'b0;
    pops_req  = 0;
    pops_done = 0;
    src_valid = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    step();
    step();
    rst_n       = 1'b1;
    fifo_count  = '0;
    fcount_next = 0;
    for (int i = 0; i < N; i++) acc_tot[i] = 0;
    push_total  = 0;
    run_src     = -1;
    run_len     = 0;
    max_run     = 0;
    grant_log.delete();
    rec_on      = 1'b0;
    rec_started = 1'b0;
    rec_n       = 0;
    hist        = '0;
    ord_on      = 1'b0;
    ord_seq     = 0;
  endtask

  initial begin
    int exp_order [5];
    int guard;
    exp_order = '{0, 1, 2, 3, 0};
    n_chk = 0;
    n_pass = 0;
    m_ok = 1'b0;
    m_owner = -1;
    m_last = N - 1;
    m_gid = 0;
    m_beats = 0;
    m_push = 1'b0;
    m_data = '0;
    acc_flag = '0;
    gv_prev = 1'b0;
    fcount_next = 0;
    fifo_count = '0;
    pops_req = 0;
    pops_done = 0;
    drain = 1'b1;
    rnd_v = 1'b0;
    rec_on = 1'b0;
    ord_on = 1'b0;
    enable = 1'b1;
    rst_n = 1'b0;
    src_data = '0;
    src_valid = '1;
    for (int i = 0; i < N; i++) begin
      rem[i] = -1;
      seq[i] = 0;
      acc_tot[i] = 0;
    end

    // Reset held two cycles with every source requesting.
    step();
    step();
    #1;
    chk("rst_src_ready", 128'(src_ready), 128'(0));
    chk("rst_fifo_push", 128'(fifo_push), 128'(0));
    chk("rst_grant_valid", 128'(grant_valid), 128'(0));
    chk("rst_accept_cnt", 128'(accept_cnt), 128'(0));

    // Single source 2, ten events, FIFO draining.
    do_reset();
    rem[2] = 10;
    rec_on = 1'b1;
    ord_on = 1'b1;
    repeat (60) step();
    rec_on = 1'b0;
    ord_on = 1'b0;
    chk("p2_push_pattern", 128'(hist), 128'(12'b1111_0111_1011));
    chk("p2_push_count", 128'(push_total), 128'(10));
    chk("p2_order_total", 128'(ord_seq), 128'(10));
    chk("p2_accept_cnt2", 128'(accept_cnt[2*CNT_W +: CNT_W]), 128'(10));

    // All sources continuously valid: rotation 0,1,2,3,0 with full bursts.
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = -1;
    repeat (30) step();
    chk("p3_grant_count", 128'(grant_log.size() >= 5), 128'(1));
    for (int k = 0; k < 5; k++) begin
      chk("p3_grant_order", 128'((k < grant_log.size()) ? grant_log[k] : -1), 128'(exp_order[k]));
    end
    chk("p3_max_run", 128'(max_run), 128'(BURST));

    // FIFO never popped: exactly DEPTH pushes, then one pop buys one more.
    do_reset();
    drain = 1'b0;
    rem[0] = -1;
    repeat (40) step();
    chk("p4_pushes_full", 128'(push_total), 128'(DEPTH));
    chk("p4_count_full", 128'(fifo_count), 128'(DEPTH));
    #1;
    chk("p4_ready_full", 128'(src_ready), 128'(0));
    pops_req = 1;
    repeat (8) step();
    chk("p4_pushes_after_pop", 128'(push_total), 128'(DEPTH + 1));
    chk("p4_count_after_pop", 128'(fifo_count), 128'(DEPTH));

    // Enable dropped after the second beat of a burst.
    do_reset();
    rem[1] = -1;
    guard = 0;
    while (acc_tot[1] < 2 && guard < 20) begin
      step();
      guard++;
    end
    chk("p5_two_beats", 128'(acc_tot[1]), 128'(2));
    enable = 1'b0;
    #1;
    chk("p5_ready_drop", 128'(src_ready), 128'(0));
    chk("p5_still_grant", 128'(grant_valid), 128'(1));
    step();
    chk("p5_exit", 128'(grant_valid), 128'(0));
    repeat (4) begin
      step();
      chk("p5_no_grant", 128'(grant_valid), 128'(0));
    end
    enable = 1'b1;
    step();
    chk("p5_regrant", 128'(grant_valid), 128'(1));
    chk("p5_regrant_id", 128'(grant_id), 128'(1));

    // Counter saturation: 20 accepts on source 1 with 4-bit counters.
    do_reset();
    rem[1] = 20;
    repeat (60) step();
    chk("p6_accepts", 128'(acc_tot[1]), 128'(20));
    chk("p6_saturated", 128'(accept_cnt[1*CNT_W +: CNT_W]), 128'(CMAX));

    // Random traffic, enable, pops and occasional mid-stream resets.
    do_reset();
    rnd_v = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = -1;
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(7) != 0);
      if (c % 64 == 0) drain = ($urandom_range(1) == 1);
      if (!drain && pops_done == pops_req && $urandom_range(3) == 0) pops_req++;
      rst_n = ($urandom_range(199) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
